// File: rtl/power_sequencer.sv
// power_sequencer
//   Brings the three PMIC supply stages up in order (enable, wait for good,
//   settle), takes them down in reverse order on request, and latches a fault
//   on any good-flag timeout or lost rail. A fault drops every enable at once.
//
// Ports
//   i_clk            system clock
//   i_reset          synchronous active-high reset
//   i_enable         1 = power up and stay up, 0 = power down
//   i_clearFault     clears the fault latch (only while i_enable = 0)
//   i_S1Good..S3Good stage good flags (each includes the stages below it)
//   o_S1Enable..S3   regulator enables
//   o_monitorResetn  active-low clear for the rail monitor fault latches
//   o_allUp          all stages up and settled
//   o_fault          latched fault
//   o_faultStage     failing stage 1..3, 0 = no fault
//   o_faultTimeout   1 = stage never came good, 0 = stage dropped after good
module power_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 100000,
  parameter int unsigned SETTLE_CYCLES  = 1000,
  parameter int unsigned CNT_W          = 20
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_enable,
  input  logic       i_clearFault,
  input  logic       i_S1Good,
  input  logic       i_S2Good,
  input  logic       i_S3Good,
  output logic       o_S1Enable,
  output logic       o_S2Enable,
  output logic       o_S3Enable,
  output logic       o_monitorResetn,
  output logic       o_allUp,
  output logic       o_fault,
  output logic [1:0] o_faultStage,
  output logic       o_faultTimeout
);

  typedef enum logic [3:0] {
    IDLE,
    CLR,
    S1_WAIT,
    S1_SETTLE,
    S2_WAIT,
    S2_SETTLE,
    S3_WAIT,
    S3_SETTLE,
    UP,
    DOWN3,
    DOWN2,
    DOWN1,
    FAULT
  } state_t;

  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;

  logic       r_S1Enable;
  logic       r_S2Enable;
  logic       r_S3Enable;
  logic       r_monitorResetn;
  logic       r_allUp;
  logic       r_fault;
  logic [1:0] r_faultStage;
  logic       r_faultTimeout;

  logic       w_S1Enable;
  logic       w_S2Enable;
  logic       w_S3Enable;
  logic       w_monitorResetn;
  logic       w_allUp;
  logic       w_fault;
  logic [1:0] w_faultStage;
  logic       w_faultTimeout;

  logic [2:0] w_goods;
  logic [1:0] w_drop1;
  logic [1:0] w_drop2;
  logic [1:0] w_drop3;
  logic       w_timeoutHit;
  logic       w_settleHit;
  logic       w_timed;

  // Lowest stage among 1..upto whose good flag is low; 0 if none.
  function automatic logic [1:0] lowest_drop(input logic [2:0] good, input logic [1:0] upto);
    logic [1:0] stage;
    stage = 2'd0;
    if (upto >= 2'd3 && !good[2]) stage = 2'd3;
    if (upto >= 2'd2 && !good[1]) stage = 2'd2;
    if (upto >= 2'd1 && !good[0]) stage = 2'd1;
    return stage;
  endfunction

  assign w_goods      = {i_S3Good, i_S2Good, i_S1Good};
  assign w_drop1      = lowest_drop(w_goods, 2'd1);
  assign w_drop2      = lowest_drop(w_goods, 2'd2);
  assign w_drop3      = lowest_drop(w_goods, 2'd3);
  assign w_timeoutHit = (r_cnt == TIMEOUT_LAST);
  assign w_settleHit  = (r_cnt == SETTLE_LAST);
  assign w_timed      = (r_state inside {S1_WAIT, S1_SETTLE, S2_WAIT, S2_SETTLE,
                                         S3_WAIT, S3_SETTLE, DOWN3, DOWN2, DOWN1});

  // State, counter and registered outputs. Outputs are decoded from the
  // next state so they line up with the state they describe.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state         <= IDLE;
      r_cnt           <= '0;
      r_S1Enable      <= 1'b0;
      r_S2Enable      <= 1'b0;
      r_S3Enable      <= 1'b0;
      r_monitorResetn <= 1'b0;
      r_allUp         <= 1'b0;
      r_fault         <= 1'b0;
      r_faultStage    <= '0;
      r_faultTimeout  <= 1'b0;
    end else begin
      r_state <= w_next;
      // Counter restarts on every state entry and idles at 0 in untimed states.
      if (w_next != r_state || !w_timed) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
      r_S1Enable      <= w_S1Enable;
      r_S2Enable      <= w_S2Enable;
      r_S3Enable      <= w_S3Enable;
      r_monitorResetn <= w_monitorResetn;
      r_allUp         <= w_allUp;
      r_fault         <= w_fault;
      r_faultStage    <= w_faultStage;
      r_faultTimeout  <= w_faultTimeout;
    end
  end

  // Next state. In every active state the order is: lower-rail drop,
  // own timeout/drop, power-down request, normal progression.
  always_comb begin
    w_next         = r_state;
    w_faultStage   = r_faultStage;
    w_faultTimeout = r_faultTimeout;
    case (r_state)
      IDLE: begin
        if (i_enable) w_next = CLR;
      end
      CLR: begin
        w_next = i_enable ? S1_WAIT : IDLE;
      end
      S1_WAIT: begin
        if (!i_S1Good && w_timeoutHit) begin
          w_next = FAULT; w_faultStage = 2'd1; w_faultTimeout = 1'b1;
        end else if (!i_enable) begin
          w_next = DOWN1;
        end else if (i_S1Good) begin
          w_next = S1_SETTLE;
        end
      end
      S1_SETTLE: begin
        if (w_drop1 != 2'd0) begin
          w_next = FAULT; w_faultStage = w_drop1; w_faultTimeout = 1'b0;
        end else if (!i_enable) begin
          w_next = DOWN1;
        end else if (w_settleHit) begin
          w_next = S2_WAIT;
        end
      end
      S2_WAIT: begin
        if (w_drop1 != 2'd0) begin
          w_next = FAULT; w_faultStage = w_drop1; w_faultTimeout = 1'b0;
        end else if (!i_S2Good && w_timeoutHit) begin
          w_next = FAULT; w_faultStage = 2'd2; w_faultTimeout = 1'b1;
        end else if (!i_enable) begin
          w_next = DOWN2;
        end else if (i_S2Good) begin
          w_next = S2_SETTLE;
        end
      end
      S2_SETTLE: begin
        if (w_drop2 != 2'd0) begin
          w_next = FAULT; w_faultStage = w_drop2; w_faultTimeout = 1'b0;
        end else if (!i_enable) begin
          w_next = DOWN2;
        end else if (w_settleHit) begin
          w_next = S3_WAIT;
        end
      end
      S3_WAIT: begin
        if (w_drop2 != 2'd0) begin
          w_next = FAULT; w_faultStage = w_drop2; w_faultTimeout = 1'b0;
        end else if (!i_S3Good && w_timeoutHit) begin
          w_next = FAULT; w_faultStage = 2'd3; w_faultTimeout = 1'b1;
        end else if (!i_enable) begin
          w_next = DOWN3;
        end else if (i_S3Good) begin
          w_next = S3_SETTLE;
        end
      end
      S3_SETTLE: begin
        if (w_drop3 != 2'd0) begin
          w_next = FAULT; w_faultStage = w_drop3; w_faultTimeout = 1'b0;
        end else if (!i_enable) begin
          w_next = DOWN3;
        end else if (w_settleHit) begin
          w_next = UP;
        end
      end
      UP: begin
        if (w_drop3 != 2'd0) begin
          w_next = FAULT; w_faultStage = w_drop3; w_faultTimeout = 1'b0;
        end else if (!i_enable) begin
          w_next = DOWN3;
        end
      end
      DOWN3: begin
        if (w_settleHit) w_next = DOWN2;
      end
      DOWN2: begin
        if (w_settleHit) w_next = DOWN1;
      end
      DOWN1: begin
        if (w_settleHit) w_next = IDLE;
      end
      FAULT: begin
        if (i_clearFault && !i_enable) begin
          w_next = IDLE; w_faultStage = 2'd0; w_faultTimeout = 1'b0;
        end
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // Output decode of the next state.
  always_comb begin
    w_S1Enable      = 1'b0;
    w_S2Enable      = 1'b0;
    w_S3Enable      = 1'b0;
    w_monitorResetn = 1'b1;
    w_allUp         = 1'b0;
    w_fault         = 1'b0;
    case (w_next)
      CLR: w_monitorResetn = 1'b0;
      S1_WAIT, S1_SETTLE, DOWN2: w_S1Enable = 1'b1;
      S2_WAIT, S2_SETTLE, DOWN3: begin
        w_S1Enable = 1'b1;
        w_S2Enable = 1'b1;
      end
      S3_WAIT, S3_SETTLE: begin
        w_S1Enable = 1'b1;
        w_S2Enable = 1'b1;
        w_S3Enable = 1'b1;
      end
      UP: begin
        w_S1Enable = 1'b1;
        w_S2Enable = 1'b1;
        w_S3Enable = 1'b1;
        w_allUp    = 1'b1;
      end
      FAULT: w_fault = 1'b1;
      default: ;
    endcase
  end

  assign o_S1Enable      = r_S1Enable;
  assign o_S2Enable      = r_S2Enable;
  assign o_S3Enable      = r_S3Enable;
  assign o_monitorResetn = r_monitorResetn;
  assign o_allUp         = r_allUp;
  assign o_fault         = r_fault;
  assign o_faultStage    = r_faultStage;
  assign o_faultTimeout  = r_faultTimeout;

endmodule

// File: doc/power_sequencer.md
# power_sequencer

Sequences the three supply stages of the PMIC. It enables each stage in order and waits for that stage's good flag, with a timeout and a settle time per stage. When requested it shuts the stages down in reverse order. On any timeout or lost rail it drops all enables at once and latches a fault. It sits above the rail monitors and stage good generators: it consumes the stage good outputs and drives the regulator enable pins and the monitors' fault-clear reset.

## Interface
- TIMEOUT_CYCLES, 100000: maximum cycles in a WAIT state for the stage good flag.
- SETTLE_CYCLES, 1000: dwell cycles after a stage is good (power-up), or between stage turn-offs (power-down).
- CNT_W, 20: counter width; must hold max(TIMEOUT_CYCLES, SETTLE_CYCLES)-1.
- i_clk  in  1  system clock; one clock domain.
- i_reset  in  1  synchronous, active-high reset.
- i_enable  in  1  level; 1 = power up and stay up, 0 = power down.
- i_clearFault  in  1  clears the fault latch; honoured only while i_enable=0.
- i_S1Good, i_S2Good, i_S3Good  in  1 each  stage good flags; each flag already includes the stages below it.
- o_S1Enable, o_S2Enable, o_S3Enable  out  1 each  regulator enables.
- o_monitorResetn  out  1  active-low clear for the rail monitor fault latches.
- o_allUp  out  1  all stages up and settled.
- o_fault  out  1  latched fault.
- o_faultStage  out  2  failing stage (1–3); 0 = no fault.
- o_faultTimeout  out  1  1 = the stage never came good; 0 = the stage was good, then dropped.

## Operation
- States: IDLE, CLR, S1_WAIT, S1_SETTLE, S2_WAIT, S2_SETTLE, S3_WAIT, S3_SETTLE, UP, DOWN3, DOWN2, DOWN1, FAULT.
- IDLE: all enables 0. i_enable=1 -> CLR.
- CLR: one cycle with o_monitorResetn=0, then S1_WAIT.
- Sn_WAIT:
  - SnEnable=1, plus all lower enables held.
  - Counter starts at 0 on entry and increments each cycle.
  - SnGood=1 -> Sn_SETTLE.
  - Else, counter==TIMEOUT_CYCLES-1 -> FAULT with stage n, timeout=1.
  - If good arrives on the final counter cycle, good wins.
- Sn_SETTLE:
  - Counter starts at 0 on entry.
  - If SnGood stays 1 for SETTLE_CYCLES cycles: n<3 -> S(n+1)_WAIT, n=3 -> UP.
  - SnGood drop -> FAULT with stage n, timeout=0. Drop beats settle completion.
- UP: o_allUp=1. Any good flag of an enabled stage drops -> FAULT, reporting the lowest dropped stage, timeout=0.
- Good monitoring everywhere: in every WAIT/SETTLE/UP state, a drop of any lower stage's good flag -> FAULT with that stage, timeout=0. The lowest stage wins on simultaneous drops.
- Power-down request: i_enable=0 in any state from CLR through UP -> DOWNk.
  - k = the highest stage currently enabled. From CLR -> IDLE.
- DOWNk sequence:
  - SkEnable cleared on entry.
  - Wait SETTLE_CYCLES, then DOWN(k-1).
  - After DOWN1 completes -> IDLE.
  - Good drops are ignored in DOWN states.
  - i_enable=1 during DOWN does not abort: the shutdown completes to IDLE, then re-sequences from CLR.
- Fault vs disable: fault detection has priority over i_enable=0 in the same cycle.
- FAULT:
  - All enables 0 in the first FAULT cycle; no reverse sequencing.
  - o_fault=1; o_faultStage and o_faultTimeout are latched.
  - Exits only when i_clearFault=1 and i_enable=0 -> IDLE, clearing the fault fields.
  - i_clearFault while i_enable=1 is ignored.

## Timing
- All outputs are registered. A state change takes effect on outputs the cycle after the input is sampled.
- Reset values: all enables 0, o_monitorResetn 0 while i_reset=1, o_allUp 0, o_fault 0, o_faultStage 0, o_faultTimeout 0, state IDLE.
- The first cycle after reset has o_monitorResetn=1.
- Reset mid-sequence, at any state, gives the reset values on the next edge.
- Minimum power-up latency with goods already high: 1 (CLR) + 3×(1 WAIT + SETTLE_CYCLES) cycles from i_enable rising to o_allUp.
- Power-down: SkEnable falls 1 cycle after i_enable falls. Subsequent enables fall SETTLE_CYCLES apart.
- Counter never wraps; it is cleared on every state entry.

## Test plan
- Parameters TIMEOUT=20, SETTLE=4. Each good follows its enable after 3 cycles -> S1/S2/S3 enables rise in order, o_allUp=1, o_fault=0; one o_monitorResetn low pulse after i_enable.
- i_S2Good held 0 -> o_S2Enable high for exactly 20 WAIT cycles, then all enables 0, o_fault=1, o_faultStage=2, o_faultTimeout=1.
- In UP, drop i_S1Good and i_S3Good in the same cycle -> o_faultStage=1, o_faultTimeout=0, all enables 0 one cycle later.
- In UP, i_enable=0 -> S3 off, then S2 off 4 cycles later, then S1 off 4 cycles later, then IDLE. Good drops during this shutdown raise no fault.
- In FAULT, i_clearFault=1 with i_enable=1 -> fault stays latched. i_enable=0 with i_clearFault=1 -> IDLE, fault fields 0.
- i_reset=1 during S2_SETTLE -> next cycle all outputs at reset values, including o_monitorResetn=0.
